// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered ALU, single-cycle ops plus iterative MUL/MULH/DIV/REM
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int MODE_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [WIDTH-1:0]  i_l,
  input  logic [WIDTH-1:0]  i_r,
  input  logic              i_carry,
  input  logic              i_flush,
  output logic              o_ready,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_out,
  output logic [4:0]        o_flags
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_AMT = WIDTH'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [MODE_W-1:0] M_RPASS = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_ADD   = MODE_W'(2);
  localparam logic [MODE_W-1:0] M_SUB   = MODE_W'(3);
  localparam logic [MODE_W-1:0] M_AND   = MODE_W'(4);
  localparam logic [MODE_W-1:0] M_OR    = MODE_W'(5);
  localparam logic [MODE_W-1:0] M_XOR   = MODE_W'(6);
  localparam logic [MODE_W-1:0] M_SHL   = MODE_W'(7);
  localparam logic [MODE_W-1:0] M_SHR   = MODE_W'(8);
  localparam logic [MODE_W-1:0] M_MUL   = MODE_W'(9);
  localparam logic [MODE_W-1:0] M_DIV   = MODE_W'(10);
  localparam logic [MODE_W-1:0] M_ASHR  = MODE_W'(11);
  localparam logic [MODE_W-1:0] M_SEXT  = MODE_W'(12);
  localparam logic [MODE_W-1:0] M_MULH  = MODE_W'(13);
  localparam logic [MODE_W-1:0] M_REM   = MODE_W'(14);

  logic [1:0]         state, state_nxt;
  logic               ready, valid, accept, req_iter;

  logic [WIDTH-1:0]   res_reg;
  logic [4:0]         flag_reg;

  logic [MODE_W-1:0]  op_mode;
  logic [2*WIDTH-1:0] acc;      // product, or {0, dividend->quotient}
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvs;      // multiplicand or divisor
  logic [CNT_W-1:0]   cnt;

  // ---------------- single-cycle datapath (from live inputs) ----------------
  logic [WIDTH:0]     add_full, sub_full, shl_full;
  logic [WIDTH-1:0]   ashr_val, sext_val, sc_res;
  logic               sc_c, sc_o;
  logic [4:0]         sc_flags;

  assign add_full = {1'b0, i_l} + {1'b0, i_r} + {{WIDTH{1'b0}}, i_carry};
  assign sub_full = {1'b0, i_l} - {1'b0, i_r} - {{WIDTH{1'b0}}, i_carry};
  // Extra top bit catches the last bit shifted out; amounts > WIDTH flush it to 0.
  assign shl_full = {1'b0, i_l} << i_r;
  assign ashr_val = (i_r >= WIDTH_AMT) ? {WIDTH{i_l[WIDTH-1]}}
                                       : WIDTH'($signed(i_l) >>> i_r);

  generate
    if (WIDTH > 8) begin : g_sext_wide
      assign sext_val = {{(WIDTH-8){i_l[7]}}, i_l[7:0]};
    end else begin : g_sext_narrow
      assign sext_val = i_l;
    end
  endgenerate

  always_comb begin
    sc_res = i_l;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    case (i_mode)
      M_RPASS: sc_res = i_r;
      M_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_o   = (i_l[WIDTH-1] == i_r[WIDTH-1]) && (add_full[WIDTH-1] != i_l[WIDTH-1]);
      end
      M_SUB: begin
        sc_res = sub_full[WIDTH-1:0];
        sc_c   = sub_full[WIDTH];
        sc_o   = (i_l[WIDTH-1] != i_r[WIDTH-1]) && (sub_full[WIDTH-1] != i_l[WIDTH-1]);
      end
      M_AND:  sc_res = i_l & i_r;
      M_OR:   sc_res = i_l | i_r;
      M_XOR:  sc_res = i_l ^ i_r;
      M_SHL: begin
        sc_res = shl_full[WIDTH-1:0];
        sc_c   = shl_full[WIDTH];
      end
      M_SHR:  sc_res = i_l >> i_r;
      M_ASHR: sc_res = ashr_val;
      M_SEXT: sc_res = sext_val;
      default: ;
    endcase
  end

  assign sc_flags = {^sc_res, sc_o, sc_res[WIDTH-1], sc_c, ~|sc_res};
  assign req_iter = i_mode inside {M_MUL, M_MULH, M_DIV, M_REM};

  // ---------------- iterative datapath: one step per ITER cycle ----------------
  logic               op_is_mul, div_ge, hi_nz;
  logic [WIDTH:0]     mul_hi, part_rem;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_rem, it_res;
  logic               it_c, it_o;
  logic [4:0]         it_flags;

  assign op_is_mul = (op_mode == M_MUL) || (op_mode == M_MULH);
  assign mul_hi    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
  assign part_rem  = {rem, acc[WIDTH-1]};
  assign div_ge    = part_rem >= {1'b0, dvs};

  always_comb begin
    step_acc = {mul_hi, acc[WIDTH-1:1]};
    step_rem = rem;
    if (!op_is_mul) begin
      // Restoring step; a zero divisor always "fits", giving all-ones / dividend.
      step_acc = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
      step_rem = div_ge ? (part_rem[WIDTH-1:0] - dvs) : part_rem[WIDTH-1:0];
    end
  end

  always_comb begin
    it_res = step_acc[WIDTH-1:0];
    case (op_mode)
      M_MULH: it_res = step_acc[2*WIDTH-1:WIDTH];
      M_REM:  it_res = step_rem;
      default: ;
    endcase
    hi_nz = |step_acc[2*WIDTH-1:WIDTH];
    it_c  = (op_mode == M_MULH) && hi_nz;
    it_o  = ((op_mode == M_MUL) && hi_nz) || (!op_is_mul && ~|dvs);
  end

  assign it_flags = {^it_res, it_o, it_res[WIDTH-1], it_c, ~|it_res};

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: state_nxt = i_req ? (req_iter ? S_ITER : S_DONE) : S_IDLE;
        S_ITER:         if (cnt == LAST_STEP) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = 1'b1;
    valid = 1'b0;
    case (state)
      S_ITER:  ready = 1'b0;
      S_DONE:  valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = i_req && !i_flush && ready;

  // ---------------- datapath / result registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_mode  <= '0;
      acc      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      res_reg  <= '0;
      flag_reg <= '0;
    end else if (accept) begin
      op_mode <= i_mode;
      dvs     <= i_r;
      acc     <= {{WIDTH{1'b0}}, i_l};
      rem     <= '0;
      cnt     <= '0;
      if (!req_iter) begin
        res_reg  <= sc_res;
        flag_reg <= sc_flags;
      end
    end else if (state == S_ITER && !i_flush) begin
      acc <= step_acc;
      rem <= step_rem;
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST_STEP) begin
        res_reg  <= it_res;
        flag_reg <= it_flags;
      end
    end
  end

  assign o_ready = ready;
  assign o_valid = valid;
  assign o_out   = res_reg;
  assign o_flags = flag_reg;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq : vector table, multi-cycle corner sequences, randomized ops against a reference model
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, req, carry, flush;
  logic [3:0]   mode;
  logic [W-1:0] l, r;
  logic         ready, valid;
  logic [W-1:0] out;
  logic [4:0]   flags;

  int n_total = 0;
  int n_pass  = 0;

  alu_seq #(.WIDTH(W), .MODE_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mode(mode), .i_l(l), .i_r(r),
    .i_carry(carry), .i_flush(flush), .o_ready(ready), .o_valid(valid),
    .o_out(out), .o_flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: arithmetic straight from the operation definitions.
  function automatic void model(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                                input logic ci, output logic [15:0] res, output logic [4:0] fl,
                                output int lat);
    longint la = a, lb = b, p;
    int s, sa, sb, ts, idx;
    logic cf = 1'b0, of = 1'b0;
    sa  = a[15] ? int'(a) - 65536 : int'(a);
    sb  = b[15] ? int'(b) - 65536 : int'(b);
    p   = la * lb;
    lat = 1;
    res = a;
    case (m)
      4'd1: res = b;
      4'd2: begin
        s = int'(a) + int'(b) + int'(ci); res = s[15:0]; cf = (s > 65535);
        ts = sa + sb + int'(ci); of = (ts > 32767) || (ts < -32768);
      end
      4'd3: begin
        s = int'(a) - int'(b) - int'(ci); res = s[15:0]; cf = (s < 0);
        ts = sa - sb - int'(ci); of = (ts > 32767) || (ts < -32768);
      end
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: begin
        res = (b >= 16) ? 16'h0000 : 16'(la << b);
        if (b >= 1 && b <= 16) begin idx = 16 - int'(b); cf = a[idx]; end
      end
      4'd8: res = (b >= 16) ? 16'h0000 : 16'(la >> b);
      4'd9: begin res = p[15:0]; of = (p[31:16] != 0); lat = 17; end
      4'd10: begin
        lat = 17;
        if (b == 0) begin res = 16'hFFFF; of = 1'b1; end else res = 16'(la / lb);
      end
      4'd11: res = (b >= 16) ? (a[15] ? 16'hFFFF : 16'h0000) : 16'(sa >>> b);
      4'd12: res = a[7] ? (a | 16'hFF00) : (a & 16'h00FF);
      4'd13: begin res = p[31:16]; cf = (res != 0); lat = 17; end
      4'd14: begin
        lat = 17;
        if (b == 0) begin res = a; of = 1'b1; end else res = 16'(la % lb);
      end
      default: res = a;
    endcase
    fl = {1'($countones(res) % 2), of, res[15], cf, (res == 0)};
  endfunction

  // Issue one op, scramble inputs after accept, wait (bounded) for o_valid.
  task automatic do_op(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, output logic [15:0] o, output logic [4:0] f,
                       output int lat, output int busy);
    int guard = 0;
    while (!ready && guard < 50) begin @(posedge clk); #1; guard++; end
    req = 1'b1; mode = m; l = a; r = b; carry = ci;
    @(posedge clk); #1;
    req = 1'b0; mode = 4'($urandom); l = 16'($urandom); r = 16'($urandom); carry = 1'($urandom);
    lat = 1; busy = 0;
    while (!valid && lat <= 40) begin
      if (!ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    o = out; f = flags;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [15:0] a, b;
    logic        c;
    logic [15:0] eout;
    logic [4:0]  eflags;
    int          elat;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [3:0] m, input logic [15:0] a,
                              input logic [15:0] b, input logic c, input logic [15:0] eo,
                              input logic [4:0] ef, input int el);
    vec_t v;
    v.name = n; v.mode = m; v.a = a; v.b = b; v.c = c;
    v.eout = eo; v.eflags = ef; v.elat = el;
    return v;
  endfunction

  initial begin
    vec_t         vecs[$];
    logic [15:0]  got_o, exp_o, last_out;
    logic [4:0]   got_f, exp_f, last_flags;
    int           lat, busy, exp_lat, nv;
    logic [3:0]   rm;
    logic [15:0]  ra, rb;
    logic         rc;

    //                 name          mode   l         r         c     out       {P,O,N,C,Z}  lat
    vecs.push_back(mk("add_wrap",    4'd2,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b00011, 1));
    vecs.push_back(mk("sub_ovf",     4'd3,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b11000, 1));
    vecs.push_back(mk("lpass",       4'd0,  16'h00FF, 16'h1234, 1'b0, 16'h00FF, 5'b00000, 1));
    vecs.push_back(mk("add_cin_ovf", 4'd2,  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b11100, 1));
    vecs.push_back(mk("sub_borrow",  4'd3,  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 5'b00110, 1));
    vecs.push_back(mk("mul",         4'd9,  16'h1234, 16'h5678, 1'b0, 16'h0060, 5'b01000, 17));
    vecs.push_back(mk("mulh",        4'd13, 16'h1234, 16'h5678, 1'b0, 16'h0626, 5'b10010, 17));
    vecs.push_back(mk("div",         4'd10, 16'h03E8, 16'h0007, 1'b0, 16'h008E, 5'b00000, 17));
    vecs.push_back(mk("rem",         4'd14, 16'h03E8, 16'h0007, 1'b0, 16'h0006, 5'b00000, 17));
    vecs.push_back(mk("div0",        4'd10, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 5'b01100, 17));
    vecs.push_back(mk("rem0",        4'd14, 16'h1234, 16'h0000, 1'b0, 16'h1234, 5'b11000, 17));
    vecs.push_back(mk("shl16",       4'd7,  16'h0001, 16'h0010, 1'b0, 16'h0000, 5'b00011, 1));
    vecs.push_back(mk("shl1",        4'd7,  16'h8001, 16'h0001, 1'b0, 16'h0002, 5'b10010, 1));
    vecs.push_back(mk("ashr20",      4'd11, 16'h8000, 16'h0014, 1'b0, 16'hFFFF, 5'b00100, 1));
    vecs.push_back(mk("shr0",        4'd8,  16'h8000, 16'h0000, 1'b0, 16'h8000, 5'b10100, 1));
    vecs.push_back(mk("sext",        4'd12, 16'h0080, 16'h0000, 1'b0, 16'hFF80, 5'b10100, 1));
    vecs.push_back(mk("rpass",       4'd1,  16'h0000, 16'h8001, 1'b0, 16'h8001, 5'b00100, 1));
    vecs.push_back(mk("mode15",      4'd15, 16'hABCD, 16'h1111, 1'b0, 16'hABCD, 5'b00100, 1));

    rst_n = 1'b0; req = 1'b0; mode = '0; l = '0; r = '0; carry = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_out",   out,   0);
    check("rst_flags", flags, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- vector table ----
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, got_o, got_f, lat, busy);
      check({vecs[i].name, "_out"},   got_o, vecs[i].eout);
      check({vecs[i].name, "_flags"}, got_f, vecs[i].eflags);
      check({vecs[i].name, "_lat"},   lat,   vecs[i].elat);
      check({vecs[i].name, "_busy"},  busy,  vecs[i].elat - 1);
    end

    // ---- back-to-back: new request accepted in the o_valid cycle ----
    req = 1'b1; mode = 4'd3; l = 16'h8000; r = 16'h0001; carry = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_sub_valid", valid, 1);
    check("b2b_sub_out",   out,   16'h7FFF);
    check("b2b_ready_done", ready, 1);
    req = 1'b1; mode = 4'd0; l = 16'h00FF;
    @(posedge clk); #1;
    req = 1'b0;
    check("b2b_lpass_valid", valid, 1);
    check("b2b_lpass_out",   out,   16'h00FF);
    check("b2b_lpass_flags", flags, 5'b00000);
    @(posedge clk); #1;
    check("b2b_pulse_end", valid, 0);
    last_out = 16'h00FF; last_flags = 5'b00000;

    // ---- flush in the middle of a MUL ----
    req = 1'b1; mode = 4'd9; l = 16'h1234; r = 16'h5678;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", ready, 1);
    nv = 0;
    repeat (25) begin if (valid) nv++; @(posedge clk); #1; end
    check("flush_no_valid", nv, 0);
    check("flush_out_kept", out, last_out);
    check("flush_flags_kept", flags, last_flags);

    // ---- flush together with a request in IDLE: not accepted ----
    req = 1'b1; flush = 1'b1; mode = 4'd2; l = 16'h0001; r = 16'h0001;
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    check("flushreq_ready", ready, 1);
    nv = 0;
    repeat (3) begin if (valid) nv++; @(posedge clk); #1; end
    check("flushreq_no_valid", nv, 0);
    check("flushreq_out_kept", out, last_out);

    // ---- requests during ITER are ignored; operands captured at accept ----
    model(4'd10, 16'h1234, 16'h0011, 1'b0, exp_o, exp_f, exp_lat);
    req = 1'b1; mode = 4'd10; l = 16'h1234; r = 16'h0011;
    @(posedge clk); #1;
    req = 1'b0; lat = 1;
    while (!valid && lat <= 40) begin
      if (lat == 3) begin req = 1'b1; mode = 4'd2; l = 16'($urandom); r = 16'($urandom); end
      if (lat == 9) req = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_lat", lat, exp_lat);
    check("ignore_out", out, exp_o);
    check("ignore_flags", flags, exp_f);
    nv = 0;
    repeat (5) begin @(posedge clk); #1; if (valid) nv++; end
    check("ignore_not_queued", nv, 0);

    // ---- asynchronous reset in the middle of a DIV ----
    req = 1'b1; mode = 4'd10; l = 16'h03E8; r = 16'h0007;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out",   out,   0);
    check("arst_flags", flags, 0);
    check("arst_valid", valid, 0);
    check("arst_ready", ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nv = 0;
    repeat (25) begin if (valid) nv++; @(posedge clk); #1; end
    check("arst_no_valid", nv, 0);

    // ---- randomized ops against the reference model ----
    for (int i = 0; i < 150; i++) begin
      rm = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if ((rm inside {4'd7, 4'd8, 4'd11}) && $urandom_range(0, 1) == 1)
        rb = 16'($urandom_range(0, 20));
      if ((rm inside {4'd10, 4'd14}) && $urandom_range(0, 7) == 0)
        rb = 16'h0000;
      model(rm, ra, rb, rc, exp_o, exp_f, exp_lat);
      do_op(rm, ra, rb, rc, got_o, got_f, lat, busy);
      check($sformatf("rand%0d_m%0d_out", i, rm),   got_o, exp_o);
      check($sformatf("rand%0d_m%0d_flags", i, rm), got_f, exp_f);
      check($sformatf("rand%0d_m%0d_lat", i, rm),   lat,   exp_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the core's combinational ALU. It adds real iterative MUL, MULH, DIV and REM, using a shift-add multiplier and a restoring divider. The block sits in the execute stage behind a req/ready/valid handshake, so the pipeline can stall on multi-cycle ops. All results and flags are registered outputs.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
MODE_W, 4, width of i_mode

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_req  input  1  operation request; accepted only when o_ready=1
i_mode  input  MODE_W  operation select (encoding below)
i_l  input  WIDTH  left operand
i_r  input  WIDTH  right operand / shift amount / divisor
i_carry  input  1  carry/borrow in (ADD/SUB only)
i_flush  input  1  abort the in-flight op
o_ready  output  1  idle, can accept i_req
o_valid  output  1  one-cycle pulse: o_out/o_flags updated
o_out  output  WIDTH  result, held until next o_valid
o_flags  output  5  {P,O,N,C,Z} = bits [4:0] = P4 O3 N2 C1 Z0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: o_ready=1, o_valid=0, o_out=0, o_flags=0; FSM in IDLE; iteration counter and datapath registers cleared. Reset mid-operation discards the op with no o_valid.
- Modes:
  - 0 LPASS, 1 RPASS, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR.
  - 9 MUL (low WIDTH bits), 10 DIV (unsigned quotient), 11 ASHR, 12 SEXT (sign-extend bit 7).
  - 13 MULH (high WIDTH bits of the unsigned product), 14 REM (unsigned remainder), 15 behaves as LPASS.
- FSM states:
  - IDLE: o_ready=1. i_req & ~i_flush -> operands and mode latched. Single-cycle modes go to DONE; MUL/MULH/DIV/REM go to ITER.
  - ITER: o_ready=0. Performs one shift-add or restoring-subtract step per cycle for exactly WIDTH cycles, then goes to DONE.
  - DONE: o_valid=1 for one cycle; o_out and o_flags written; o_ready=1 in the same cycle. A new i_req is accepted in DONE (back-to-back), so DONE behaves as IDLE plus a result pulse.
- Latency, from the accepting edge to the o_valid cycle:
  - 1 cycle for single-cycle modes.
  - WIDTH+1 cycles for iterative modes.
  - Throughput is 1 op/cycle for single-cycle modes.
- i_req while o_ready=0: ignored, not queued. The requester holds i_req until it sees o_ready.
- i_flush: highest priority. Any state -> IDLE at the next edge; no o_valid; o_out/o_flags unchanged. i_flush together with i_req in IDLE means no accept.
- Arithmetic:
  - ADD: {C,out} = i_l + i_r + i_carry.
  - SUB: out = i_l - i_r - i_carry; C = borrow.
  - Iterative modes operate on WIDTH-bit unsigned operands, with a 2*WIDTH product accumulator and a WIDTH+1 partial remainder.
- Shifts:
  - Amount is the full i_r value.
  - SHL/SHR with amount >= WIDTH give 0.
  - ASHR with amount >= WIDTH gives all copies of i_l[WIDTH-1].
  - Amount 0 passes i_l through.
- Flags, computed on the final registered result:
  - Z = result == 0; N = result MSB; P = XOR-reduction of the result.
  - C: ADD/SUB carry or borrow; SHL = last bit shifted out (i_l[WIDTH-amt] for 1<=amt<=WIDTH, else 0); MULH = high half nonzero; 0 otherwise.
  - O: signed overflow for ADD/SUB; MUL = high half nonzero; divide-by-zero = 1; 0 otherwise.
- Divide by zero: DIV gives all-ones, REM gives i_l, O=1. The op still takes WIDTH+1 cycles so timing does not depend on data.
- Operand registers are captured at accept. Changes on i_l/i_r/i_mode/i_carry during ITER have no effect.

Test Plan:
- ADD 0xFFFF+0x0001, i_carry=0 (WIDTH=16) -> o_valid exactly 1 cycle after accept, o_out=0x0000, Z=1, C=1, O=0.
- SUB 0x8000-0x0001, i_carry=0 -> o_out=0x7FFF, O=1, C=0, N=0. Then back-to-back LPASS 0x00FF on the o_valid cycle -> o_out=0x00FF one cycle later, P=0.
- MUL 0x1234*0x5678 -> o_valid 17 cycles after accept, o_out=0x0060, O=1, o_ready=0 cycles 1..16. Then MULH on the same operands -> 0x0626, C=1.
- DIV 1000/7 -> 0x008E; REM 1000/7 -> 0x0006. DIV 0x1234/0 -> 0xFFFF, O=1. REM 0x1234/0 -> 0x1234, O=1. All take 17 cycles.
- i_flush at cycle 5 of a MUL -> o_ready=1 next cycle, no o_valid, o_out keeps its previous value. i_rst_n low mid-DIV -> outputs zero immediately (async), no o_valid after release.
- Shift boundaries:
  - SHL 0x0001 by 16 -> 0x0000, C=1, Z=1.
  - ASHR 0x8000 by 20 -> 0xFFFF.
  - SHR 0x8000 by 0 -> 0x8000.
  - SEXT 0x0080 -> 0xFF80.
